muon_pulse_gen: RTL and testbench
=================================

Name: muon_pulse_gen

Overview:
- On-chip stimulus source for the muon-lifetime front end: the transmitting end of the detector-pulse interface that the coincidence counters and TDC receive.
- Emits programmable bursts of A/B/C detector pulses for self-test and bring-up without physical paddles.
- Outputs are OR-ed with the debounced button inputs ahead of the counter/TDC core.

Parameters:
- PULSE_CYCLES, 15, high time of every generated pulse (150 ns at 100 MHz).
- GAP_CYCLES, 50, idle cycles before each event (500 ns).
- DELAY_W, 16, width of the A/B-to-C delay field.
- COUNT_W, 8, width of the burst length and the sent-event counter.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a burst
- abort  in  1  synchronous abort of the current burst
- mode  in  2  event type: 0 A only, 1 B only, 2 coincidence plus C, 3 coincidence with no C (TDC timeout)
- delay  in  DELAY_W  cycles from A/B deassert to C assert, used in mode 2 only
- count  in  COUNT_W  number of events in the burst
- pulse_a  out  1  detector A pulse
- pulse_b  out  1  detector B pulse
- pulse_c  out  1  detector C pulse
- busy  out  1  high from the accept cycle until return to IDLE
- done  out  1  one-cycle strobe at normal burst completion
- events_sent  out  COUNT_W  events completed in the current or last burst

Behaviour:
- All outputs are registered. Reset value of every output is 0. FSM resets to IDLE.
- IDLE:
  - start=1 with count!=0: latch mode, delay and count; clear events_sent; busy=1 next cycle; go to GAP.
  - start with count==0: ignored.
  - start while busy: ignored.
  - Config changes during a burst have no effect.
- GAP: all pulses low for exactly GAP_CYCLES cycles, then go to PULSE_AB.
- PULSE_AB: lasts exactly PULSE_CYCLES cycles.
  - mode 0: pulse_a high.
  - mode 1: pulse_b high.
  - modes 2/3: pulse_a and pulse_b high in the same cycles.
  - Next state: mode 2 goes to WAIT_C; all other modes go to NEXT.
- WAIT_C: pulses low for exactly the latched delay cycles.
  - delay=0 means pulse_c rises in the cycle immediately after pulse_a/b fall.
  - Then go to PULSE_C.
- PULSE_C: pulse_c high for PULSE_CYCLES cycles, then go to NEXT.
- NEXT (one cycle):
  - events_sent increments.
  - If events_sent+1 == latched count: done=1 for this cycle, busy drops, go to IDLE.
  - Otherwise go to GAP.
- Event period:
  - modes 0/1/3: GAP+PULSE+1 cycles (66 by default).
  - mode 2: GAP+2*PULSE+delay+1 cycles.
- Counters:
  - Cycle counter is DELAY_W bits wide. delay=2^DELAY_W-1 must count fully with no wrap.
  - events_sent holds its value after the burst ends and clears on the next accepted start.
- abort in any non-IDLE state:
  - Next cycle: all pulses 0, busy 0, state IDLE, no done.
  - events_sent keeps the count of completed events.
  - An aborted event is not counted.
- start and abort in the same cycle while IDLE: start wins; abort has no effect in IDLE.
- rst_n low at any time, including mid-pulse: outputs clear immediately (asynchronous).
- A/B overlap never extends past PULSE_CYCLES, so the receiver counts exactly one coincidence per mode-2/3 event.

Optional Feature:
- Macro: MUON_PULSE_GEN_LFSR_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1, reloaded on reset) advances once per entry to PULSE_AB.
  - The effective C delay is (lfsr & delay), giving pseudo-random decay times bounded by the delay input.
  - The LFSR never reaches zero.
- Not defined: the delay is exactly the latched delay value; no LFSR logic is synthesized.

Decomposition:
- Shared package muon_pkg:
  - mode encoding constants MODE_A=0, MODE_B=1, MODE_ABC=2, MODE_AB_TIMEOUT=3.
  - FSM state typedef (IDLE, GAP, PULSE_AB, WAIT_C, PULSE_C, NEXT).
  - LFSR seed and tap constants.
- One natural sub-module: muon_lfsr16 (enable, rst_n, 16-bit state out), instantiated only under the macro.

Test Plan:
- mode=2, delay=10, count=1 after reset:
  - pulse_a and pulse_b rise together 51 cycles after start and are high 15 cycles.
  - pulse_c rises 10 cycles after they fall and is high 15 cycles.
  - done rises 1 cycle after pulse_c falls.
  - events_sent=1; the receiving TDC reads 25 cycles rise-to-rise.
- mode=1, count=50: exactly 50 pulse_b pulses, each 15 cycles, period 66; done once; events_sent=50; pulse_a and pulse_c stay 0 throughout.
- mode=3, count=5: 5 coincident A/B pulses, pulse_c never asserts, done after 330 cycles; the receiver TDC shows its timeout value.
- mode=2, delay=0 and delay=16'hFFFF: C follows A/B fall by exactly 0 and 65535 cycles; no counter wrap.
- count=3, abort asserted mid-second PULSE_AB: outputs 0 next cycle, busy=0, done never pulses, events_sent=1; a following start with count=0 is ignored.
- rst_n pulled low during PULSE_C: pulse_c clears without waiting for a clock edge; after release, state is IDLE and busy=0.
- With MUON_PULSE_GEN_LFSR_EN defined: the delay sequence equals a reference model of the LFSR masked by delay, and no delay exceeds the delay input.

Source files
------------

// File: rtl/muon_pkg.sv
// Shared constants and types for the muon detector-pulse generator.
package muon_pkg;

    // Default timing and field widths
    localparam int unsigned DEF_PULSE_CYCLES = 15;
    localparam int unsigned DEF_GAP_CYCLES   = 50;
    localparam int unsigned DEF_DELAY_W      = 16;
    localparam int unsigned DEF_COUNT_W      = 8;

    // Event-type encoding on the mode input
    localparam logic [1:0] MODE_A          = 2'd0;
    localparam logic [1:0] MODE_B          = 2'd1;
    localparam logic [1:0] MODE_ABC        = 2'd2;
    localparam logic [1:0] MODE_AB_TIMEOUT = 2'd3;

    // Pseudo-random decay LFSR: x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form
    localparam int unsigned LFSR_W    = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GAP      = 3'd1,
        PULSE_AB = 3'd2,
        WAIT_C   = 3'd3,
        PULSE_C  = 3'd4,
        NEXT     = 3'd5
    } state_t;

endpackage

// File: rtl/muon_lfsr16.sv
// 16-bit Fibonacci LFSR; steps once per enable, reloads its seed on reset.
module muon_lfsr16
    import muon_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic [LFSR_W-1:0] state
);

    // Shift right, feeding the tap parity into the MSB; a nonzero seed never reaches zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LFSR_SEED;
        end else if (enable) begin
            state <= {^(state & LFSR_TAPS), state[LFSR_W-1:1]};
        end
    end

endmodule

// File: rtl/muon_pulse_gen.sv
// Programmable A/B/C detector-pulse burst generator for front-end self-test.
// Optional macro MUON_PULSE_GEN_LFSR_EN masks the C delay with a 16-bit LFSR.
module muon_pulse_gen
    import muon_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int unsigned GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int unsigned DELAY_W      = DEF_DELAY_W,
    parameter int unsigned COUNT_W      = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [DELAY_W-1:0] delay,
    input  logic [COUNT_W-1:0] count,
    output logic               pulse_a,
    output logic               pulse_b,
    output logic               pulse_c,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] events_sent
);

    localparam logic [DELAY_W-1:0] GAP_LAST   = DELAY_W'(GAP_CYCLES - 1);
    localparam logic [DELAY_W-1:0] PULSE_LAST = DELAY_W'(PULSE_CYCLES - 1);

    state_t             state_q, state_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] events_d;
    logic               pulse_a_d, pulse_b_d, pulse_c_d, busy_d, done_d;
    logic [DELAY_W-1:0] c_delay;

`ifdef MUON_PULSE_GEN_LFSR_EN
    logic              lfsr_step;
    logic [LFSR_W-1:0] lfsr;

    // Advance the LFSR on every entry into PULSE_AB
    assign lfsr_step = (state_q == GAP) && (cnt_q == GAP_LAST) && !abort;

    muon_lfsr16 u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (lfsr_step),
        .state  (lfsr)
    );

    // Pseudo-random decay time, never larger than the latched delay
    assign c_delay = delay_q & DELAY_W'(lfsr);
`else
    // Fixed decay time
    assign c_delay = delay_q;
`endif

    // State, cycle counter, latched configuration and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mode_q      <= MODE_A;
            delay_q     <= '0;
            count_q     <= '0;
            pulse_a     <= 1'b0;
            pulse_b     <= 1'b0;
            pulse_c     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            events_sent <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            delay_q     <= delay_d;
            count_q     <= count_d;
            pulse_a     <= pulse_a_d;
            pulse_b     <= pulse_b_d;
            pulse_c     <= pulse_c_d;
            busy        <= busy_d;
            done        <= done_d;
            events_sent <= events_d;
        end
    end

    // Next-state, counter and output decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        delay_d  = delay_q;
        count_d  = count_q;
        events_d = events_sent;
        busy_d   = busy;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && (count != '0)) begin
                    mode_d   = mode;
                    delay_d  = delay;
                    count_d  = count;
                    events_d = '0;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = GAP;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = PULSE_AB;
                end else begin
                    cnt_d = cnt_q + DELAY_W'(1);
                end
            end
            PULSE_AB: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d = '0;
                    if (mode_q != MODE_ABC) begin
                        state_d = NEXT;
                    end else if (c_delay == '0) begin
                        state_d = PULSE_C;
                    end else begin
                        state_d = WAIT_C;
                    end
                end else begin
                    cnt_d = cnt_q + DELAY_W'(1);
                end
            end
            WAIT_C: begin
                // Only entered with a nonzero delay, so delay-1 cannot underflow
                if (cnt_q == (c_delay - DELAY_W'(1))) begin
                    cnt_d   = '0;
                    state_d = PULSE_C;
                end else begin
                    cnt_d = cnt_q + DELAY_W'(1);
                end
            end
            PULSE_C: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = NEXT;
                end else begin
                    cnt_d = cnt_q + DELAY_W'(1);
                end
            end
            NEXT: begin
                events_d = events_sent + COUNT_W'(1);
                if (events_d == count_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Abort discards the event in flight without counting it
        if ((state_q != IDLE) && abort) begin
            state_d  = IDLE;
            cnt_d    = '0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            events_d = events_sent;
        end

        // Pulses track the upcoming state so they line up with it exactly
        pulse_a_d = (state_d == PULSE_AB) && (mode_q != MODE_B);
        pulse_b_d = (state_d == PULSE_AB) && (mode_q != MODE_A);
        pulse_c_d = (state_d == PULSE_C);
    end

endmodule

// File: tb/tb_muon_pulse_gen.sv
// Self-checking bench for muon_pulse_gen: burst vector table plus corner-case sequences.
module tb_muon_pulse_gen;
    import muon_pkg::*;

    localparam int DW      = 16;
    localparam int CW      = 8;
    localparam int T_GAP   = 50;
    localparam int T_PULSE = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [1:0]    mode;
    logic [DW-1:0] delay;
    logic [CW-1:0] count;
    logic          pulse_a, pulse_b, pulse_c, busy, done;
    logic [CW-1:0] events_sent;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] lfsr_m;

    typedef struct {
        logic [1:0]    mode;
        logic [DW-1:0] delay;
        int            count;
        int            done_idx;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    muon_pulse_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .mode        (mode),
        .delay       (delay),
        .count       (count),
        .pulse_a     (pulse_a),
        .pulse_b     (pulse_b),
        .pulse_c     (pulse_c),
        .busy        (busy),
        .done        (done),
        .events_sent (events_sent)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

`ifdef MUON_PULSE_GEN_LFSR_EN
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction
`endif

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        lfsr_m = 16'hACE1;
        start  = 1'b0;
        abort  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Run one burst and measure pulse timing cycle by cycle (index k = cycles after start)
    task automatic run_vec(input vec_t v, input int idx);
        int  n_ab = 0, n_c = 0, bad_len = 0, bad_per = 0, bad_gap = 0, bad_ch = 0;
        int  n_done = 0, done_k = -1, ab_first = -1;
        int  ab_rise_k = 0, ab_fall_k = 0, c_rise_k = 0;
        int  exp_gap = 0, prev_period = 0, cur_period = 0, dyn_done = 1, exp_done;
        logic prev_ab = 1'b0, prev_c = 1'b0, ab;
        string tag;
        tag = $sformatf("vec%0d", idx);

        @(negedge clk);
        mode  = v.mode;
        delay = v.delay;
        count = CW'(v.count);
        start = 1'b1;
        for (int k = 1; k <= v.done_idx + 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            ab = pulse_a | pulse_b;
            if (ab && !prev_ab) begin
                n_ab++;
                if (n_ab == 1) ab_first = k;
                else if (k - ab_rise_k != prev_period) bad_per++;
                ab_rise_k = k;
`ifdef MUON_PULSE_GEN_LFSR_EN
                lfsr_m  = lfsr_next(lfsr_m);
                exp_gap = int'(lfsr_m & v.delay);
`else
                exp_gap = int'(v.delay);
`endif
                cur_period  = (v.mode == 2'd2) ? (T_GAP + 2 * T_PULSE + exp_gap + 1)
                                               : (T_GAP + T_PULSE + 1);
                prev_period = cur_period;
                dyn_done   += cur_period;
            end
            if (!ab && prev_ab) begin
                if (k - ab_rise_k != T_PULSE) bad_len++;
                ab_fall_k = k;
            end
            if (pulse_c && !prev_c) begin
                n_c++;
                if (k - ab_fall_k != exp_gap) bad_gap++;
                c_rise_k = k;
            end
            if (!pulse_c && prev_c && (k - c_rise_k != T_PULSE)) bad_len++;
            case (v.mode)
                2'd0:    if (pulse_b) bad_ch++;
                2'd1:    if (pulse_a) bad_ch++;
                default: if (pulse_a != pulse_b) bad_ch++;
            endcase
            if (done) begin
                n_done++;
                done_k = k;
            end
            prev_ab = ab;
            prev_c  = pulse_c;
        end

        exp_done = v.done_idx;
`ifdef MUON_PULSE_GEN_LFSR_EN
        if (v.mode == 2'd2) exp_done = dyn_done;
`endif
        check({tag, " ab_first_rise"}, ab_first, T_GAP + 1);
        check({tag, " ab_pulses"}, n_ab, v.count);
        check({tag, " c_pulses"}, n_c, (v.mode == 2'd2) ? v.count : 0);
        check({tag, " bad_widths"}, bad_len, 0);
        check({tag, " bad_periods"}, bad_per, 0);
        check({tag, " bad_c_delay"}, bad_gap, 0);
        check({tag, " wrong_channel"}, bad_ch, 0);
        check({tag, " done_pulses"}, n_done, 1);
        check({tag, " done_cycle"}, done_k, exp_done);
        check({tag, " events_sent"}, events_sent, v.count);
        check({tag, " busy_end"}, busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        mode  = 2'd0;
        delay = '0;
        count = '0;
        lfsr_m = 16'hACE1;

        // period mode2 = 81 + delay, others 66; done observed one cycle after last NEXT
        vecs[0] = '{2'd2, 16'd10,    1,  92};
        vecs[1] = '{2'd1, 16'd0,    50,  3301};
        vecs[2] = '{2'd3, 16'd7,     5,  331};
        vecs[3] = '{2'd2, 16'd0,     1,  82};
        vecs[4] = '{2'd2, 16'hFFFF,  1,  65617};
        vecs[5] = '{2'd0, 16'd3,     2,  133};
        vecs[6] = '{2'd2, 16'd5,     3,  259};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst pulse_a", pulse_a, 0);
        check("rst pulse_b", pulse_b, 0);
        check("rst pulse_c", pulse_c, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst events_sent", events_sent, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Abort mid second PULSE_AB; a start while busy changes nothing
        do_reset();
        @(negedge clk);
        mode = 2'd3; delay = '0; count = 8'd3; start = 1'b1;
        begin
            int n_done = 0;
            for (int k = 1; k <= 140; k++) begin
                @(negedge clk);
                start = 1'b0;
                abort = 1'b0;
                if (done) n_done++;
                if (k == 10) begin
                    start = 1'b1; mode = 2'd0; count = 8'd7;
                end
                if (k == 51) check("busy_start_ignored pulse_b", pulse_b, 1);
                if (k == 120) begin
                    check("abort pre pulse_a", pulse_a, 1);
                    abort = 1'b1;
                end
                if (k == 121) begin
                    check("abort pulse_a", pulse_a, 0);
                    check("abort pulse_b", pulse_b, 0);
                    check("abort busy", busy, 0);
                    check("abort events_sent", events_sent, 1);
                end
            end
            check("abort done_pulses", n_done, 0);
        end
        @(negedge clk);
        start = 1'b1; count = 8'd0; mode = 2'd0;
        @(negedge clk);
        start = 1'b0;
        check("count0 busy", busy, 0);
        @(negedge clk);
        check("count0 busy2", busy, 0);
        check("count0 events_sent", events_sent, 1);

        // start and abort together in IDLE: start wins
        do_reset();
        @(negedge clk);
        mode = 2'd0; count = 8'd1; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort busy", busy, 1);
        check("start_abort events_sent", events_sent, 0);
        for (int k = 2; k <= 51; k++) @(negedge clk);
        check("start_abort pulse_a", pulse_a, 1);

        // Async reset during PULSE_C
        do_reset();
        @(negedge clk);
        mode = 2'd2; delay = 16'd10; count = 8'd1; start = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_rst pulse_c", pulse_c, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst pulse_c", pulse_c, 0);
        check("async_rst busy", busy, 0);
        lfsr_m = 16'hACE1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst busy", busy, 0);
        check("post_rst pulse_c", pulse_c, 0);
        mode = 2'd1; count = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("post_rst restart busy", busy, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
